// File: rtl/ether_rx_if.sv
// RMII receive interface: PHY-side carrier/data in, payload dibit stream
// and frame status pulses out.
interface ether_rx_if;
    logic       crsdv;
    logic [1:0] rxd;
    logic       axiov;
    logic [1:0] axiod;
    logic       done;
    logic       err;

    // The master side drives the PHY inputs and consumes the payload stream.
    modport master (
        output crsdv, rxd,
        input  axiov, axiod, done, err
    );

    // The receiver consumes the PHY inputs and produces the payload stream.
    modport slave (
        input  crsdv, rxd,
        output axiov, axiod, done, err
    );
endinterface

// File: rtl/ether_rx.sv
// RMII receive front end. Validates the preamble and SFD, strips both, and
// forwards the payload, including the FCS, as a dibit stream. The output is
// registered, so it lags the sampled rxd by one cycle. The done pulse closes
// a frame. The err pulse reports a preamble or SFD violation.
//
// state | meaning
// WAIT  | ignore the line until carrier drops (after reset or an error)
// IDLE  | line quiet, waiting for the first preamble dibit
// PREAM | counting 2'b01 dibits, expecting SFD 2'b11 after the last one
// DATA  | forwarding payload dibits until carrier drops
module ether_rx #(
    parameter int PREAMBLE_DIBITS = 31
) (
    input  logic       clk,
    input  logic       rst,
    ether_rx_if.slave  rx
);

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        IDLE  = 2'd1,
        PREAM = 2'd2,
        DATA  = 2'd3
    } state_t;

    localparam logic [4:0] PRE_CNT  = 5'(PREAMBLE_DIBITS);
    localparam logic [1:0] DIB_PRE  = 2'b01;
    localparam logic [1:0] DIB_SFD  = 2'b11;

    state_t     state_q;
    logic [4:0] cnt_q;
    logic       axiov_q;
    logic [1:0] axiod_q;
    logic       done_q;
    logic       err_q;

    // Single-process FSM. The pulse and data outputs default low every cycle,
    // so axiod is 2'b00 whenever axiov is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT;
            cnt_q   <= 5'd0;
            axiov_q <= 1'b0;
            axiod_q <= 2'b00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            axiov_q <= 1'b0;
            axiod_q <= 2'b00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                WAIT: begin
                    if (!rx.crsdv) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (rx.crsdv) begin
                        if (rx.rxd == DIB_PRE) begin
                            state_q <= PREAM;
                            cnt_q   <= 5'd1;
                        end else begin
                            state_q <= WAIT;
                            err_q   <= 1'b1;
                        end
                    end
                end
                PREAM: begin
                    if (!rx.crsdv) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else if (cnt_q < PRE_CNT) begin
                        if (rx.rxd == DIB_PRE) begin
                            cnt_q <= cnt_q + 5'd1;
                        end else begin
                            state_q <= WAIT;
                            err_q   <= 1'b1;
                        end
                    end else begin
                        // A full preamble has been seen. Only the SFD is legal
                        // here, so one more 2'b01 is an error.
                        if (rx.rxd == DIB_SFD) begin
                            state_q <= DATA;
                        end else begin
                            state_q <= WAIT;
                            err_q   <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (rx.crsdv) begin
                        axiov_q <= 1'b1;
                        axiod_q <= rx.rxd;
                    end else begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= WAIT;
                end
            endcase
        end
    end

    assign rx.axiov = axiov_q;
    assign rx.axiod = axiod_q;
    assign rx.done  = done_q;
    assign rx.err   = err_q;

endmodule

// File: tb/tb_ether_rx.sv
// Self-checking bench for ether_rx. Expected payload dibits are queued as
// they are driven. A negedge monitor pops and compares them, and it counts
// the done/err pulses and the axiov runs for the scenario tasks to check.
module tb_ether_rx;

    logic clk;
    logic rst;

    ether_rx_if bus ();

    ether_rx #(.PREAMBLE_DIBITS(31)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [1:0] exp_q [$];
    logic       mon_en = 1'b0;
    int         n_done, n_err, n_valid, n_runs, run, last_run;
    logic       prev_axiov;
    logic       done_prev_v, done_cur_v;

    localparam logic [63:0] PAY_A = 64'h676960d19d785a5b;
    localparam logic [63:0] PAY_B = 64'hA5C30F1E778899BB;

    // Negedge monitor: scoreboard compare plus pulse and run bookkeeping.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.axiov === 1'b1) begin
                n_valid++;
                run++;
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_axiov: axiod=%b with no expected dibit", bus.axiod);
                end else begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    if (bus.axiod !== e) $display("FAIL payload_dibit: got %b expected %b", bus.axiod, e);
                    else passes++;
                end
            end else begin
                checks++;
                if (bus.axiod !== 2'b00 || bus.axiov !== 1'b0)
                    $display("FAIL idle_outputs: axiov=%b axiod=%b expected 0/00", bus.axiov, bus.axiod);
                else passes++;
                if (run != 0) begin
                    last_run = run;
                    n_runs++;
                    run = 0;
                end
            end
            if (bus.done === 1'b1) begin
                n_done++;
                done_prev_v = prev_axiov;
                done_cur_v  = bus.axiov;
            end
            if (bus.err === 1'b1) n_err++;
            if (bus.done === 1'b1 || bus.err === 1'b1) begin
                checks++;
                if (bus.done === 1'b1 && bus.err === 1'b1)
                    $display("FAIL done_err_overlap: done=%b err=%b both high", bus.done, bus.err);
                else passes++;
            end
            prev_axiov = bus.axiov;
        end
    end

    task automatic clr();
        n_done = 0; n_err = 0; n_valid = 0; n_runs = 0; run = 0; last_run = 0;
        done_prev_v = 1'b0; done_cur_v = 1'b0;
    endtask

    task automatic send(input logic c, input logic [1:0] d);
        bus.crsdv = c;
        bus.rxd   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 2'b00);
    endtask

    task automatic preamble(input int n);
        for (int i = 0; i < n; i++) send(1'b1, 2'b01);
    endtask

    task automatic payload(input logic [63:0] v, input int first, input int last, input bit expect_out);
        logic [63:0] w;
        w = v;
        for (int i = first; i <= last; i++) begin
            if (expect_out) exp_q.push_back(w[2*i +: 2]);
            send(1'b1, w[2*i +: 2]);
        end
    endtask

    task automatic good_frame(input logic [63:0] v);
        preamble(31);
        send(1'b1, 2'b11);
        payload(v, 0, 31, 1'b1);
        send(1'b0, 2'b00);
    endtask

    task automatic check_good(input string name, input int exp_done, input int exp_err);
        checks++;
        if (n_done !== exp_done) $display("FAIL %s_done: got %0d expected %0d", name, n_done, exp_done);
        else passes++;
        checks++;
        if (n_err !== exp_err) $display("FAIL %s_err: got %0d expected %0d", name, n_err, exp_err);
        else passes++;
        checks++;
        if (last_run !== 32) $display("FAIL %s_run: got %0d expected 32", name, last_run);
        else passes++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL %s_leftover: got %0d expected 0", name, exp_q.size());
        else passes++;
        checks++;
        if (done_prev_v !== 1'b1 || done_cur_v !== 1'b0)
            $display("FAIL %s_done_align: prev/cur axiov %b/%b expected 1/0", name, done_prev_v, done_cur_v);
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.crsdv = 1'b0;
        bus.rxd   = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({bus.axiov, bus.axiod, bus.done, bus.err} !== 5'b0)
            $display("FAIL reset_outputs: got %b expected 00000", {bus.axiov, bus.axiod, bus.done, bus.err});
        else passes++;
        rst = 1'b0;
        idle(2);
        clr();
        prev_axiov = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_good_frame();
        clr();
        good_frame(PAY_A);
        idle(2);
        check_good("good", 1, 0);
        checks++;
        if (n_valid !== 32 || n_runs !== 1)
            $display("FAIL good_valid_cycles: got %0d in %0d runs expected 32 in 1", n_valid, n_runs);
        else passes++;
    endtask

    task automatic test_pre_error();
        clr();
        preamble(9);
        send(1'b1, 2'b10);
        preamble(25);
        send(1'b1, 2'b11);
        preamble(4);
        idle(2);
        checks++;
        if (n_err !== 1) $display("FAIL pre10_err: got %0d expected 1", n_err);
        else passes++;
        checks++;
        if (n_valid !== 0 || n_done !== 0)
            $display("FAIL pre10_quiet: valid %0d done %0d expected 0 0", n_valid, n_done);
        else passes++;
        clr();
        good_frame(PAY_B);
        idle(2);
        check_good("pre10_recover", 1, 0);
    endtask

    task automatic test_no_sfd();
        clr();
        preamble(32);
        send(1'b1, 2'b11);
        payload(PAY_A, 0, 7, 1'b0);
        idle(2);
        checks++;
        if (n_err !== 1) $display("FAIL nosfd_err: got %0d expected 1", n_err);
        else passes++;
        checks++;
        if (n_valid !== 0 || n_done !== 0)
            $display("FAIL nosfd_quiet: valid %0d done %0d expected 0 0", n_valid, n_done);
        else passes++;
    endtask

    task automatic test_carrier_loss();
        clr();
        preamble(20);
        send(1'b0, 2'b00);
        good_frame(PAY_A);
        idle(2);
        check_good("crsloss", 1, 1);
    endtask

    task automatic test_reset_mid_frame();
        clr();
        preamble(31);
        send(1'b1, 2'b11);
        payload(PAY_B, 0, 4, 1'b1);
        rst = 1'b1;
        send(1'b1, PAY_B[11:10]);
        rst = 1'b0;
        checks++;
        if (bus.axiov !== 1'b0 || bus.axiod !== 2'b00)
            $display("FAIL rst_mid_out: axiov=%b axiod=%b expected 0/00", bus.axiov, bus.axiod);
        else passes++;
        preamble(6);
        send(1'b1, 2'b11);
        payload(PAY_B, 6, 31, 1'b0);
        idle(1);
        idle(2);
        checks++;
        if (n_valid !== 5 || n_err !== 0 || n_done !== 0)
            $display("FAIL rst_mid_quiet: valid %0d err %0d done %0d expected 5 0 0", n_valid, n_err, n_done);
        else passes++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL rst_mid_leftover: got %0d expected 0", exp_q.size());
        else passes++;
        clr();
        good_frame(PAY_A);
        idle(2);
        check_good("rst_recover", 1, 0);
    endtask

    task automatic test_empty_frame();
        clr();
        preamble(31);
        send(1'b1, 2'b11);
        send(1'b0, 2'b00);
        idle(2);
        checks++;
        if (n_done !== 1 || n_err !== 0 || n_valid !== 0)
            $display("FAIL empty_frame: done %0d err %0d valid %0d expected 1 0 0", n_done, n_err, n_valid);
        else passes++;
    endtask

    task automatic test_back_to_back();
        clr();
        good_frame(PAY_A);
        good_frame(PAY_B);
        idle(2);
        check_good("b2b", 2, 0);
        checks++;
        if (n_valid !== 64 || n_runs !== 2)
            $display("FAIL b2b_valid: got %0d in %0d runs expected 64 in 2", n_valid, n_runs);
        else passes++;
    endtask

    initial begin
        rst = 1'b1;
        bus.crsdv = 1'b0;
        bus.rxd = 2'b00;
        test_reset();
        test_good_frame();
        test_pre_error();
        test_no_sfd();
        test_carrier_loss();
        test_reset_mid_frame();
        test_empty_frame();
        test_back_to_back();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ether_rx.md
# ether_rx

RMII receive front end for the Ethernet ingress pipeline. Samples the PHY's carrier-sense/data-valid and 2-bit receive data and validates the 7-byte preamble and SFD. Strips both and forwards only the frame payload, including the FCS, as a dibit stream on an axiov/axiod handshake. The next stage downstream is the dibit-order/CRC32-bzip2 check stage. Also emits one-cycle `done` and `err` pulses that frame-level logic uses to close or discard a frame.

## Interface
- PREAMBLE_DIBITS, 31, number of 2'b01 dibits required before the SFD dibit 2'b11. The default 31 = 7×0x55 plus the first three dibits of 0xD5.
- clk  in  1  system clock (50 MHz RMII reference clock).
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- crsdv  in  1  RMII carrier sense / data valid.
- rxd  in  2  RMII receive dibit; rxd[0] is the earlier bit on the wire.
- axiov  out  1  payload dibit valid.
- axiod  out  2  payload dibit, passed through unchanged from rxd.
- done  out  1  one-cycle pulse: frame ended after a valid SFD.
- err  out  1  one-cycle pulse: preamble/SFD violation or carrier loss inside the preamble.

## Operation
- States and counter:
  - Four states: WAIT, IDLE, PREAM, DATA.
  - 5-bit counter `cnt` holds the number of 2'b01 dibits accepted so far.
- WAIT (reset state): wait for a quiet line.
  - crsdv==0 → IDLE.
  - Otherwise stay; all inputs are ignored and no err is raised.
- IDLE:
  - crsdv==1 && rxd==2'b01 → PREAM, cnt=1.
  - crsdv==1 && any other rxd → WAIT, err pulse.
  - crsdv==0 → stay.
- PREAM:
  - crsdv==0 → IDLE, err pulse.
  - cnt<PREAMBLE_DIBITS: rxd==2'b01 → cnt+1; anything else → WAIT, err pulse.
  - cnt==PREAMBLE_DIBITS: rxd==2'b11 → DATA; anything else → WAIT, err pulse. A 32nd 2'b01 is therefore an error.
- DATA:
  - crsdv==1 → forward rxd as a payload dibit.
  - crsdv==0 → IDLE, done pulse.
  - No length limit.
- Outputs:
  - All outputs are registered.
  - axiod is 2'b00 whenever axiov is 0.
  - err and done never assert in the same cycle.
- Reset values: state=WAIT, cnt=0, axiov=0, axiod=2'b00, done=0, err=0.
- Reset mid-frame: outputs are 0 the cycle after rst is sampled. The remainder of the frame is ignored, with no err, until crsdv is sampled low.

## Timing
- Latency is 1 cycle. The rxd sampled at edge N appears on axiod after edge N (valid during cycle N+1).
- SFD dibit:
  - Never forwarded.
  - The first payload dibit is the one sampled on the edge after the SFD is sampled.
- Frame end:
  - axiov falls in the same cycle the done pulse is high, i.e. the cycle after crsdv is sampled low.
  - A frame with zero payload dibits produces done with axiov never high.
- err is high for exactly the cycle after the offending sample.
- Back-to-back frames:
  - A single crsdv-low cycle between frames is sufficient.
  - A frame whose first preamble dibit arrives in the cycle after the done-triggering sample is accepted.
- No backpressure: the downstream stage must accept one dibit per cycle.

## Test plan
- Reset, then crsdv=1 with 31×2'b01, 2'b11, then the 32 dibits of 64'h676960d19d785a5b, then crsdv=0.
  - axiov is high for exactly 32 consecutive cycles, starting one cycle after the first payload sample.
  - axiod matches the input dibit sequence.
  - Exactly one done pulse occurs, coincident with axiov falling; err stays 0.
- Dibit 2'b10 at preamble position 10.
  - err pulses once and axiov stays 0.
  - The following 2'b01 dibits in the same carrier do not start a frame.
  - After a crsdv-low gap, a good frame is received correctly.
- 32×2'b01 then 2'b11 (no SFD at position 32) → err pulse at position 32, no axiov, no done.
- crsdv drops after 20 preamble dibits → err pulse, no done. A good frame one cycle later is fully received.
- rst asserted for one cycle at payload dibit 5 of a good frame.
  - axiov=0 from the next cycle.
  - The remaining payload contains 2'b01/2'b11 patterns but produces no output and no err.
  - The next frame is received correctly.
- Valid preamble+SFD followed immediately by crsdv=0 → done pulse, axiov never high, err 0.
